// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: ADSR state encodings, datapath widths and
// the sequencer FSM encoding.
package synth_pkg;

  localparam int STATE_W  = 4;
  localparam int ENV_W    = 33;
  localparam int SAMPLE_W = 16;

  localparam logic [STATE_W-1:0] ST_OFF     = 4'd0;
  localparam logic [STATE_W-1:0] ST_ATTACK  = 4'd1;
  localparam logic [STATE_W-1:0] ST_DECAY   = 4'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE = 4'd3;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  function automatic logic is_active(input logic [STATE_W-1:0] st);
    return st != ST_OFF;
  endfunction

endpackage

// File: rtl/adsr_voice_sequencer_if.sv
// Link between the voice sequencer (master) and the shared ADSR envelope core (slave).
interface adsr_voice_sequencer_if;
  import synth_pkg::*;

  logic                       key_state;
  logic [STATE_W-1:0]         state_current;
  logic [ENV_W-1:0]           envelope_current;
  logic [STATE_W-1:0]         state_next;
  logic [ENV_W-1:0]           envelope_next;
  logic signed [SAMPLE_W-1:0] voice_sample;

  modport master (
    output key_state, state_current, envelope_current,
    input  state_next, envelope_next, voice_sample
  );

  modport slave (
    input  key_state, state_current, envelope_current,
    output state_next, envelope_next, voice_sample
  );

endinterface

// File: rtl/voice_state_ram.sv
// Per-voice ADSR state/envelope store: one combinational read port for issue,
// one synchronous write port for capture.
module voice_state_ram import synth_pkg::*; #(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VOICE_W-1:0]    rd_idx,
  output logic [STATE_W-1:0]    rd_state,
  output logic [ENV_W-1:0]      rd_env,
  input  logic                  wr_en,
  input  logic [VOICE_W-1:0]    wr_idx,
  input  logic [STATE_W-1:0]    wr_state,
  input  logic [ENV_W-1:0]      wr_env,
  output logic [NUM_VOICES-1:0] active
);

  logic [STATE_W-1:0] state_mem_r [NUM_VOICES];
  logic [ENV_W-1:0]   env_mem_r   [NUM_VOICES];

  // Entry storage, written by the capture stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_mem_r[v] <= ST_OFF;
        env_mem_r[v]   <= '0;
      end
    end else if (wr_en) begin
      state_mem_r[wr_idx] <= wr_state;
      env_mem_r[wr_idx]   <= wr_env;
    end
  end

  assign rd_state = state_mem_r[rd_idx];
  assign rd_env   = env_mem_r[rd_idx];

  // Per-voice activity flags straight from stored state
  always_comb begin
    active = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active[v] = is_active(state_mem_r[v]);
    end
  end

endmodule

// File: rtl/adsr_voice_sequencer.sv
// Time-multiplexes NUM_VOICES voices through the shared ADSR core once per
// sample tick, writes back core results and mixes the per-voice samples.
module adsr_voice_sequencer import synth_pkg::*; #(
  parameter int NUM_VOICES = 8,
  parameter int VOICE_W    = 3,
  parameter int CORE_LAT   = 1,
  parameter int MIX_W      = 16 + VOICE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic                     note_on_valid,
  input  logic [VOICE_W-1:0]       note_on_voice,
  input  logic                     note_off_valid,
  input  logic [VOICE_W-1:0]       note_off_voice,
  adsr_voice_sequencer_if.master   core,
  output logic signed [MIX_W-1:0]  mix_out,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [NUM_VOICES-1:0]    voice_active
);

  localparam int DRAIN_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(CORE_LAT - 1);
  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

  seq_state_e               state_r, state_nxt_s;
  logic [VOICE_W-1:0]       issue_idx_r;
  logic [DRAIN_W-1:0]       drain_cnt_r;
  logic                     issue_s;
  logic [CORE_LAT-1:0]      cap_vld_pipe_r;
  logic [VOICE_W-1:0]       cap_idx_pipe_r [CORE_LAT];
  logic                     cap_vld_s;
  logic [VOICE_W-1:0]       cap_idx_s;
  logic [NUM_VOICES-1:0]    key_r, key_nxt_s;
  logic signed [MIX_W-1:0]  acc_r, acc_sum_s;
  logic signed [MIX_W-1:0]  mix_out_r;
  logic                     mix_valid_r, busy_r, overrun_r;
  logic [STATE_W-1:0]       rd_state_s;
  logic [ENV_W-1:0]         rd_env_s;

  // Sweep sequencing: next state and issue strobe
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        if (sample_tick) state_nxt_s = SEQ_ISSUE;
        else             state_nxt_s = SEQ_IDLE;
      end
      SEQ_ISSUE: begin
        issue_s = 1'b1;
        if (issue_idx_r == LAST_VOICE) state_nxt_s = SEQ_DRAIN;
        else                           state_nxt_s = SEQ_ISSUE;
      end
      SEQ_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_nxt_s = SEQ_DONE;
        else                           state_nxt_s = SEQ_DRAIN;
      end
      SEQ_DONE:  state_nxt_s = SEQ_IDLE;
      default:   state_nxt_s = SEQ_IDLE;
    endcase
  end

  // FSM state, issue index and drain counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= SEQ_IDLE;
      issue_idx_r <= '0;
      drain_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) issue_idx_r <= issue_idx_r + VOICE_W'(1);
      else         issue_idx_r <= '0;
      if (state_r == SEQ_DRAIN) drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
      else                      drain_cnt_r <= '0;
    end
  end

  // Issue index delayed by the core latency selects the write-back entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld_pipe_r <= '0;
      for (int k = 0; k < CORE_LAT; k++) cap_idx_pipe_r[k] <= '0;
    end else begin
      cap_vld_pipe_r[0] <= issue_s;
      cap_idx_pipe_r[0] <= issue_idx_r;
      for (int k = 1; k < CORE_LAT; k++) begin
        cap_vld_pipe_r[k] <= cap_vld_pipe_r[k-1];
        cap_idx_pipe_r[k] <= cap_idx_pipe_r[k-1];
      end
    end
  end

  assign cap_vld_s = cap_vld_pipe_r[CORE_LAT-1];
  assign cap_idx_s = cap_idx_pipe_r[CORE_LAT-1];

  voice_state_ram #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_W    (VOICE_W)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (issue_idx_r),
    .rd_state (rd_state_s),
    .rd_env   (rd_env_s),
    .wr_en    (cap_vld_s),
    .wr_idx   (cap_idx_s),
    .wr_state (core.state_next),
    .wr_env   (core.envelope_next),
    .active   (voice_active)
  );

  // Key updates; a release beats a press on the same voice
  always_comb begin
    key_nxt_s = key_r;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (note_off_valid && (note_off_voice == VOICE_W'(v)))
        key_nxt_s[v] = 1'b0;
      else if (note_on_valid && (note_on_voice == VOICE_W'(v)))
        key_nxt_s[v] = 1'b1;
      else
        key_nxt_s[v] = key_r[v];
    end
  end

  // Running mix including the sample captured this cycle
  always_comb begin
    if (cap_vld_s)
      acc_sum_s = acc_r + {{(MIX_W-SAMPLE_W){core.voice_sample[SAMPLE_W-1]}}, core.voice_sample};
    else
      acc_sum_s = acc_r;
  end

  // Key array, accumulator and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r       <= '0;
      acc_r       <= '0;
      mix_out_r   <= '0;
      mix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      key_r <= key_nxt_s;
      if ((state_r == SEQ_IDLE) && sample_tick) acc_r <= '0;
      else                                      acc_r <= acc_sum_s;
      if (state_nxt_s == SEQ_DONE) mix_out_r <= acc_sum_s;
      mix_valid_r <= (state_nxt_s == SEQ_DONE);
      busy_r      <= (state_nxt_s == SEQ_ISSUE) || (state_nxt_s == SEQ_DRAIN);
      overrun_r   <= sample_tick && (state_r != SEQ_IDLE);
    end
  end

  // Present the issued voice to the core; idle cycles drive zeros
  always_comb begin
    if (issue_s) begin
      core.key_state        = key_r[issue_idx_r];
      core.state_current    = rd_state_s;
      core.envelope_current = rd_env_s;
    end else begin
      core.key_state        = 1'b0;
      core.state_current    = ST_OFF;
      core.envelope_current = '0;
    end
  end

  assign mix_out   = mix_out_r;
  assign mix_valid = mix_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_adsr_voice_sequencer.sv
// Self-checking bench: behavioural ADSR core, sweep-level reference model,
// note-event vector table, overrun/reset corner cases and randomized sweeps.
module tb_adsr_voice_sequencer;
  import synth_pkg::*;

  localparam int NV = 8;
  localparam int VW = 3;
  localparam int MW = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic note_on_valid = 1'b0, note_off_valid = 1'b0;
  logic [VW-1:0] note_on_voice = '0, note_off_voice = '0;
  logic signed [MW-1:0] mix_out;
  logic mix_valid, busy, overrun;
  logic [NV-1:0] voice_active;

  adsr_voice_sequencer_if core_if();

  adsr_voice_sequencer #(.NUM_VOICES(NV), .VOICE_W(VW), .CORE_LAT(1), .MIX_W(MW)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .note_on_valid(note_on_valid), .note_on_voice(note_on_voice),
    .note_off_valid(note_off_valid), .note_off_voice(note_off_voice),
    .core(core_if), .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .voice_active(voice_active)
  );

  always #5 clk = ~clk;

  // Behavioural core: attack adds 0x1000 per step, release subtracts it
  typedef struct packed { logic [3:0] st; logic [32:0] env; logic [15:0] smp; } core_res_t;
  int core_mode = 0;

  function automatic core_res_t core_fn(input logic key, input logic [3:0] st,
                                        input logic [32:0] env, input int mode);
    core_res_t r;
    if (key) begin
      r.st = ST_ATTACK; r.env = env + 33'h1000;
    end else if (st != ST_OFF && env > 33'h1000) begin
      r.st = ST_RELEASE; r.env = env - 33'h1000;
    end else begin
      r.st = ST_OFF; r.env = 33'h0;
    end
    if (mode == 1)      r.smp = 16'h7FFF;
    else if (mode == 2) r.smp = 16'h8000;
    else                r.smp = env[27:12];
    return r;
  endfunction

  logic lat_key = 1'b0;
  logic [3:0] lat_st = 4'd0;
  logic [32:0] lat_env = 33'd0;
  core_res_t core_res;
  always @(posedge clk) begin
    lat_key <= core_if.key_state;
    lat_st  <= core_if.state_current;
    lat_env <= core_if.envelope_current;
  end
  assign core_res = core_fn(lat_key, lat_st, lat_env, core_mode);
  assign core_if.state_next    = core_res.st;
  assign core_if.envelope_next = core_res.env;
  assign core_if.voice_sample  = core_res.smp;

  int ovr_cnt = 0, mv_cnt = 0;
  always @(negedge clk) begin
    if (overrun === 1'b1)   ovr_cnt <= ovr_cnt + 1;
    if (mix_valid === 1'b1) mv_cnt  <= mv_cnt + 1;
  end

  // Reference model state
  bit          key_m [NV];
  logic [3:0]  st_m  [NV];
  logic [32:0] env_m [NV];
  longint      acc_m;
  logic        obs_key [NV];
  logic [3:0]  obs_st  [NV];
  logic [32:0] obs_env [NV];
  bit          rnd_ev = 1'b0;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      key_m[v] = 1'b0; st_m[v] = 4'd0; env_m[v] = 33'd0;
    end
  endtask

  function automatic logic [7:0] model_active();
    logic [7:0] m = 8'h00;
    for (int v = 0; v < NV; v++) m[v] = (st_m[v] != 4'd0);
    return m;
  endfunction

  task automatic cyc(input logic tick, input logic on_v, input int on_i,
                     input logic off_v, input int off_i);
    sample_tick    = tick;
    note_on_valid  = on_v;  note_on_voice  = VW'(on_i);
    note_off_valid = off_v; note_off_voice = VW'(off_i);
    @(posedge clk);
    if (reset) begin
      if (on_v)  key_m[on_i]  = 1'b1;
      if (off_v) key_m[off_i] = 1'b0;
    end
    #1;
    sample_tick = 1'b0; note_on_valid = 1'b0; note_off_valid = 1'b0;
  endtask

  task automatic ev_cyc(input logic tick);
    if (rnd_ev)
      cyc(tick, ($urandom_range(0, 3) == 0), int'($urandom_range(0, NV-1)),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, NV-1)));
    else
      cyc(tick, 1'b0, 0, 1'b0, 0);
  endtask

  // One full sweep starting with a tick now; optional extra tick at cycle T+ovr_at
  task automatic run_sweep(input int ovr_at);
    core_res_t r;
    acc_m = 0;
    ev_cyc(1'b1);
    for (int i = 0; i < NV; i++) begin
      obs_key[i] = core_if.key_state;
      obs_st[i]  = core_if.state_current;
      obs_env[i] = core_if.envelope_current;
      check($sformatf("key_state[%0d]", i), 64'(core_if.key_state), 64'(key_m[i]));
      check($sformatf("state_cur[%0d]", i), 64'(core_if.state_current), 64'(st_m[i]));
      check($sformatf("env_cur[%0d]", i), 64'(core_if.envelope_current), 64'(env_m[i]));
      check($sformatf("busy_issue[%0d]", i), 64'(busy), 64'd1);
      r = core_fn(key_m[i], st_m[i], env_m[i], core_mode);
      st_m[i] = r.st; env_m[i] = r.env;
      acc_m += longint'(signed'(r.smp));
      ev_cyc(ovr_at == i + 1);
    end
    check("busy_drain", 64'(busy), 64'd1);
    check("mix_valid_drain", 64'(mix_valid), 64'd0);
    check("state_cur_drain", 64'(core_if.state_current), 64'd0);
    ev_cyc(ovr_at == 9);
    check("mix_valid_done", 64'(mix_valid), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("mix_out", 64'(longint'(mix_out)), 64'(acc_m));
    check("voice_active", 64'(voice_active), 64'(model_active()));
    check("env_cur_done", 64'(core_if.envelope_current), 64'd0);
    ev_cyc(ovr_at == 10);
    check("mix_valid_after", 64'(mix_valid), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic on_v; int on_i; logic off_v; int off_i; logic [7:0] exp_keys;
  } kev_t;
  kev_t ktab [6];

  initial begin
    int ovr0, mv0;
    logic [7:0] kmask;

    ktab[0] = '{1'b1, 5, 1'b1, 5, 8'h00};
    ktab[1] = '{1'b1, 2, 1'b1, 6, 8'h04};
    ktab[2] = '{1'b1, 6, 1'b0, 0, 8'h44};
    ktab[3] = '{1'b1, 2, 1'b1, 6, 8'h04};
    ktab[4] = '{1'b1, 7, 1'b1, 2, 8'h80};
    ktab[5] = '{1'b1, 0, 1'b1, 7, 8'h01};

    model_reset();
    #2 reset = 1'b0;
    #10;
    check("rst_mix_out", 64'(mix_out), 64'd0);
    check("rst_mix_valid", 64'(mix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_key_state", 64'(core_if.key_state), 64'd0);
    check("rst_state_cur", 64'(core_if.state_current), 64'd0);
    check("rst_env_cur", 64'(core_if.envelope_current), 64'd0);
    check("rst_voice_active", 64'(voice_active), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 0, 1'b0, 0);

    // All keys off
    ovr0 = ovr_cnt; mv0 = mv_cnt;
    run_sweep(0);
    check("idle_mix_zero", 64'(mix_out), 64'd0);
    check("idle_no_overrun", 64'(ovr_cnt - ovr0), 64'd0);
    check("idle_one_mix_valid", 64'(mv_cnt - mv0), 64'd1);

    // Voice 3 attack over several sweeps
    cyc(1'b0, 1'b1, 3, 1'b0, 0);
    run_sweep(0);
    run_sweep(0);
    check("v3_state_sweep2", 64'(obs_st[3]), 64'd1);
    check("v3_env_sweep2", 64'(obs_env[3]), 64'h1000);
    check("v3_voice_active", 64'(voice_active), 64'h08);
    run_sweep(0);
    check("v3_env_sweep3", 64'(obs_env[3]), 64'h2000);

    // Full-scale mixes
    core_mode = 1; run_sweep(0);
    check("mix_max", 64'(longint'(mix_out)), 64'd262136);
    core_mode = 2; run_sweep(0);
    check("mix_min", 64'(longint'(mix_out)), 64'(-64'sd262144));
    core_mode = 0;

    // Note-event table
    cyc(1'b0, 1'b0, 0, 1'b1, 3);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, ktab[k].on_v, ktab[k].on_i, ktab[k].off_v, ktab[k].off_i);
      run_sweep(0);
      kmask = 8'h00;
      for (int v = 0; v < NV; v++) kmask[v] = obs_key[v];
      check($sformatf("key_tab[%0d]", k), 64'(kmask), 64'(ktab[k].exp_keys));
    end

    // Tick 4 cycles into a sweep, then tick in the DONE cycle
    cyc(1'b0, 1'b1, 4, 1'b0, 0);
    ovr0 = ovr_cnt; mv0 = mv_cnt;
    run_sweep(4);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0, 0);
    check("ovr_mid_count", 64'(ovr_cnt - ovr0), 64'd1);
    check("ovr_mid_mix_count", 64'(mv_cnt - mv0), 64'd1);
    check("ovr_mid_no_resweep", 64'(busy), 64'd0);
    ovr0 = ovr_cnt; mv0 = mv_cnt;
    run_sweep(10);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0, 0);
    check("ovr_done_count", 64'(ovr_cnt - ovr0), 64'd1);
    check("ovr_done_mix_count", 64'(mv_cnt - mv0), 64'd1);
    check("ovr_done_no_resweep", 64'(busy), 64'd0);

    // Reset at T+5 of a sweep
    check("pre_rst_active", 64'(voice_active != 8'h00), 64'd1);
    mv0 = mv_cnt;
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    repeat (4) cyc(1'b0, 1'b0, 0, 1'b0, 0);
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_key_state", 64'(core_if.key_state), 64'd0);
    check("mid_rst_state_cur", 64'(core_if.state_current), 64'd0);
    check("mid_rst_env_cur", 64'(core_if.envelope_current), 64'd0);
    check("mid_rst_voice_active", 64'(voice_active), 64'd0);
    check("mid_rst_mix_out", 64'(mix_out), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) cyc(1'b0, 1'b0, 0, 1'b0, 0);
    check("mid_rst_no_mix_valid", 64'(mv_cnt - mv0), 64'd0);
    cyc(1'b0, 1'b1, 0, 1'b0, 0);
    run_sweep(0);

    // Randomized sweeps with note traffic throughout
    rnd_ev = 1'b1;
    for (int s = 0; s < 30; s++) begin
      core_mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat ($urandom_range(0, 3)) ev_cyc(1'b0);
      run_sweep(0);
    end
    rnd_ev = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_voice_sequencer.md
Name: adsr_voice_sequencer

Overview:
- Time-multiplexed driver for the shared ADSR envelope core. It is the other end of that core's state_current/envelope_current to state_next/envelope_next interface.
- Holds per-voice envelope state and key state, and presents one voice per cycle to the core on each sample tick.
- Writes back the core's next-state results and sums the core's per-voice output samples into one mixed sample per tick.
- Sits between the MIDI note-event decoder (upstream) and the output DAC/mixer path (downstream).

Parameters:
- NUM_VOICES, 8, voices per sweep; power of two, 2..32.
- VOICE_W, 3, log2(NUM_VOICES).
- CORE_LAT, 1, cycles from presenting state_current to valid state_next/output_sample; fixed at 1 for the current core.
- MIX_W, 19, mix width = 16 + VOICE_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle strobe that starts a sweep
- note_on_valid  in  1  key press event
- note_on_voice  in  VOICE_W  voice index for the press
- note_off_valid  in  1  key release event
- note_off_voice  in  VOICE_W  voice index for the release
- key_state  out  1  key of the voice being issued, to the core
- state_current  out  4  stored state of the issued voice (0 off, 1 attack, 2 decay, 3 release)
- envelope_current  out  33  stored envelope of the issued voice
- state_next  in  4  core result, captured CORE_LAT cycles after issue
- envelope_next  in  33  core result
- voice_sample  in  16 signed  core output_sample for the captured voice
- mix_out  out  MIX_W signed  sum of all voice samples from the last sweep
- mix_valid  out  1  one-cycle pulse when mix_out updates
- busy  out  1  sweep in progress
- overrun  out  1  one-cycle pulse: sample_tick arrived while busy
- voice_active  out  NUM_VOICES  bit v = (stored state of v != 0)

Behaviour:
- Reset (async, reset=0): all state/envelope/key entries 0; FSM to IDLE. key_state, state_current, envelope_current, mix_out, mix_valid, busy and overrun are 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on sample_tick at cycle T, go to ISSUE and clear the accumulator.
- ISSUE: cycles T+1..T+N issue voice index i = 0..N-1, one per cycle. Drive state_current, envelope_current and key_state from entry i.
- Key state is sampled at issue time. A key change after its voice has been issued takes effect on the next sweep.
- Capture: CORE_LAT cycles after voice i is issued:
  - write state_next and envelope_next into entry i;
  - add sign-extended voice_sample to the accumulator.
- Write index is the issue index delayed by CORE_LAT through a shift register.
- DRAIN: after the last issue, wait for the remaining CORE_LAT captures.
- DONE: at cycle T+N+CORE_LAT+1 (T+10 for the defaults):
  - load mix_out from the accumulator and pulse mix_valid;
  - return to IDLE.
- busy is high from T+1 through T+N+CORE_LAT, and low in the mix_valid cycle.
- Outside ISSUE, state_current, envelope_current and key_state are driven to 0. Core results in those cycles are ignored.
- Mix arithmetic: full-width signed sum, no saturation or rounding. MIX_W guarantees no overflow.
- Note events are accepted in any cycle, including during a sweep. They update the key array only.
  - note_on sets key[v]=1; note_off clears key[v]=0.
  - Both valid for the same voice in the same cycle: note_off wins (key=0).
  - Both valid for different voices: both apply.
- Hazards: each voice is read once and written once per sweep, with the write after the read. No forwarding is needed. Note events never touch state/envelope entries.
- sample_tick while busy or in DONE: ignored, and overrun pulses for one cycle. sample_tick in the DONE cycle counts as overrun.
- voice_active is combinational from the stored state array.
- Reset mid-sweep: everything returns to reset values immediately. No partial mix_valid is produced.

Decomposition:
- Shared package synth_pkg:
  - ADSR state encodings ST_OFF=0, ST_ATTACK=1, ST_DECAY=2, ST_RELEASE=3;
  - ENV_W=33, STATE_W=4, SAMPLE_W=16.
- Sub-module voice_state_ram: NUM_VOICES x (STATE_W+ENV_W) register array.
  - One combinational read port (issue index) and one synchronous write port (capture index).
  - Async active-low reset clears all entries.
- Key array and accumulator stay in the top level.

Test Plan:
- Reset then one sample_tick with all keys off:
  - issues voices 0..7 with state 0, envelope 0;
  - mix_valid exactly 10 cycles after the tick, mix_out=0, busy high for 9 cycles.
- note_on voice 3, then ticks, with a behavioural core model that adds 0x1000 per attack step:
  - state_current for voice 3 is 1 on the second sweep;
  - the envelope grows by 0x1000 per sweep;
  - voice_active=8'b00001000.
- Core model returns voice_sample=16'h7FFF for all 8 voices -> mix_out=+262136. All 16'h8000 -> mix_out=-262144.
- note_on and note_off for voice 5 in the same cycle -> key[5]=0. note_on voice 2 plus note_off voice 6 in the same cycle -> both apply.
- sample_tick asserted 4 cycles into a sweep:
  - overrun pulses once;
  - the sweep completes unchanged and no second sweep starts.
- Assert reset at cycle T+5 of a sweep:
  - all outputs 0 and voice_active 0;
  - no mix_valid;
  - the next tick starts cleanly from voice 0.
